wb_scoreboard: RTL and testbench

In-flight destination tracker for the five-stage pipeline. It decodes each instruction leaving fetch (after the hazard unit has substituted any NOP) and records its destination register. It shifts that record through the D/X/M/W slots in step with the pipeline registers. It produces the per-stage `regWrt*`, `wrtReg*` and `branchInst*` signals that the hazard detector compares against the fetched instruction.

---
 rtl/wb_scoreboard.sv | 138 +++++++++++++
 tb/tb_wb_scoreboard.sv | 137 +++++++++++++
 2 files changed

// File: rtl/wb_scoreboard.sv
// In-flight destination tracker: decodes the instruction entering decode and shifts {write, reg, branch, halt}
// through D/X/M/W slots. Define SCB_BUSY_VEC_EN to enable the per-register pending-write counters on `busy`.
module wb_scoreboard #(
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst_in,
  input  logic        en,
  input  logic        flush,
  output logic        regWrtD,
  output logic        regWrtX,
  output logic        regWrtM,
  output logic        regWrtW,
  output logic [2:0]  wrtRegD,
  output logic [2:0]  wrtRegX,
  output logic [2:0]  wrtRegM,
  output logic [2:0]  wrtRegW,
  output logic        branchInstD,
  output logic        branchInstX,
  output logic        haltW,
  output logic [7:0]  busy
);

  typedef struct packed {
    logic       wr;
    logic [2:0] rd;
    logic       br;
    logic       halt;
  } slot_t;

  slot_t      r_d, r_x, r_m, r_w;
  slot_t      w_dec;
  logic [4:0] w_op;

  assign w_op = inst_in[15:11];

  always_comb begin
    w_dec = '0;
    casez (w_op)
      5'b11011, 5'b11010, 5'b111??, 5'b11001: begin
        w_dec.wr = 1'b1;
        w_dec.rd = inst_in[4:2];
      end
      5'b010??, 5'b101??, 5'b10001: begin
        w_dec.wr = 1'b1;
        w_dec.rd = inst_in[7:5];
      end
      5'b10011, 5'b11000, 5'b10010: begin
        w_dec.wr = 1'b1;
        w_dec.rd = inst_in[10:8];
      end
      5'b00110, 5'b00111: begin
        w_dec.wr = 1'b1;
        w_dec.rd = 3'd7;
        w_dec.br = 1'b1;
      end
      5'b001??, 5'b011??: w_dec.br = 1'b1;
      5'b00000:           w_dec.halt = 1'b1;
      default:            w_dec = '0;
    endcase
    if (inst_in == NOP_INST) w_dec = '0;
  end

  // On flush, X survives into M only when the pipe advances; otherwise D and X are both dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d <= '0;
      r_x <= '0;
      r_m <= '0;
      r_w <= '0;
    end else if (flush) begin
      r_d <= '0;
      r_x <= '0;
      if (en) begin
        r_m <= r_x;
        r_w <= r_m;
      end
    end else if (en) begin
      r_d <= w_dec;
      r_x <= r_d;
      r_m <= r_x;
      r_w <= r_m;
    end
  end

  assign regWrtD     = r_d.wr;
  assign regWrtX     = r_x.wr;
  assign regWrtM     = r_m.wr;
  assign regWrtW     = r_w.wr;
  assign wrtRegD     = r_d.rd;
  assign wrtRegX     = r_x.rd;
  assign wrtRegM     = r_m.rd;
  assign wrtRegW     = r_w.rd;
  assign branchInstD = r_d.br;
  assign branchInstX = r_x.br;
  assign haltW       = r_w.halt;

`ifdef SCB_BUSY_VEC_EN
  logic [1:0] r_cnt [8];
  logic [1:0] w_cnt_nxt [8];
  logic [7:0] r_busy;
  logic [2:0] w_sum;
  logic [2:0] w_reg;

  // Writers counted in D, X and M; the register file bypasses writeback, so W is excluded.
  always_comb begin
    w_sum = '0;
    w_reg = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_reg = 3'(i);
      w_sum = {1'b0, r_cnt[i]};
      if (en && !flush && w_dec.wr && (w_dec.rd == w_reg)) w_sum = w_sum + 3'd1;
      if (en && r_m.wr && (r_m.rd == w_reg))               w_sum = w_sum - 3'd1;
      if (flush && r_d.wr && (r_d.rd == w_reg))            w_sum = w_sum - 3'd1;
      if (flush && !en && r_x.wr && (r_x.rd == w_reg))     w_sum = w_sum - 3'd1;
      w_cnt_nxt[i] = (w_sum > 3'd3) ? 2'd3 : w_sum[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) r_cnt[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        r_cnt[i]  <= w_cnt_nxt[i];
        r_busy[i] <= (w_cnt_nxt[i] != 2'd0);
      end
    end
  end

  assign busy = r_busy;
`else
  assign busy = '0;
`endif

endmodule

// File: tb/tb_wb_scoreboard.sv
// Scoreboard bench for wb_scoreboard: directed steps push hand-computed slot snapshots; a monitor compares each cycle.
module tb_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] inst_in = 16'h0800;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        regWrtD, regWrtX, regWrtM, regWrtW;
  logic [2:0]  wrtRegD, wrtRegX, wrtRegM, wrtRegW;
  logic        branchInstD, branchInstX, haltW;
  logic [7:0]  busy;

  always #5 clk = ~clk;

  wb_scoreboard #(.NOP_INST(16'h0800)) dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .en(en), .flush(flush),
    .regWrtD(regWrtD), .regWrtX(regWrtX), .regWrtM(regWrtM), .regWrtW(regWrtW),
    .wrtRegD(wrtRegD), .wrtRegX(wrtRegX), .wrtRegM(wrtRegM), .wrtRegW(wrtRegW),
    .branchInstD(branchInstD), .branchInstX(branchInstX), .haltW(haltW), .busy(busy)
  );

`ifdef SCB_BUSY_VEC_EN
  localparam logic BUSY_ON = 1'b1;
`else
  localparam logic BUSY_ON = 1'b0;
`endif

  localparam logic [15:0] ADD3 = 16'hD82C, LBI5 = 16'hC512, ST = 16'h8040, JAL = 16'h3004;
  localparam logic [15:0] NOP = 16'h0800, ADDI6 = 16'h40C0, LD5 = 16'h88A0;
  localparam logic [15:0] BEQZ = 16'h6000, JR = 16'h2800, HALT = 16'h0000;

  typedef struct packed {
    logic [31:0] id;
    logic [26:0] v;   // {rw[3:0], wr[11:0], br[1:0], halt, busy[7:0]}
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  task automatic step(input logic r, input logic e, input logic f, input logic [15:0] ins,
                      input logic [3:0] rw, input logic [11:0] wr, input logic [1:0] br,
                      input logic h, input logic [7:0] bz);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; flush = f; inst_in = ins;
    step_no++;
    x.id = step_no;
    x.v  = {rw, wr, br, h, bz & {8{BUSY_ON}}};
    q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      logic [26:0] act;
      x   = q.pop_front();
      act = {regWrtD, regWrtX, regWrtM, regWrtW, wrtRegD, wrtRegX, wrtRegM, wrtRegW,
             branchInstD, branchInstX, haltW, busy};
      checks++;
      if (act !== x.v) begin
        errors++;
        $display("FAIL step%0d: got rw=%b wr=%h br=%b halt=%b busy=%h, expected rw=%b wr=%h br=%b halt=%b busy=%h",
                 x.id, act[26:23], act[22:11], act[10:9], act[8], act[7:0],
                 x.v[26:23], x.v[22:11], x.v[10:9], x.v[8], x.v[7:0]);
      end
    end
  end

  initial begin
    // reset, including reset winning over en
    step(1, 0, 0, NOP,   4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h00);
    step(1, 1, 0, ADD3,  4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h00);
    // ADD r3 walks D,X,M,W then retires
    step(0, 1, 0, ADD3,  4'b1000, {3'd3,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h08);
    step(0, 1, 0, NOP,   4'b0100, {3'd0,3'd3,3'd0,3'd0}, 2'b00, 0, 8'h08);
    step(0, 1, 0, NOP,   4'b0010, {3'd0,3'd0,3'd3,3'd0}, 2'b00, 0, 8'h08);
    step(0, 1, 0, NOP,   4'b0001, {3'd0,3'd0,3'd0,3'd3}, 2'b00, 0, 8'h00);
    step(0, 1, 0, NOP,   4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h00);
    // LBI r5, ST, JAL
    step(0, 1, 0, LBI5,  4'b1000, {3'd5,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h20);
    step(0, 1, 0, ST,    4'b0100, {3'd0,3'd5,3'd0,3'd0}, 2'b00, 0, 8'h20);
    step(0, 1, 0, JAL,   4'b1010, {3'd7,3'd0,3'd5,3'd0}, 2'b10, 0, 8'hA0);
    step(0, 1, 0, NOP,   4'b0101, {3'd0,3'd7,3'd0,3'd5}, 2'b01, 0, 8'h80);
    // ADD r3 then LBI r5, flush with en=1 keeps X->M and drops D
    step(0, 1, 0, ADD3,  4'b1010, {3'd3,3'd0,3'd7,3'd0}, 2'b00, 0, 8'h88);
    step(0, 1, 0, LBI5,  4'b1101, {3'd5,3'd3,3'd0,3'd7}, 2'b00, 0, 8'h28);
    step(0, 1, 1, ADDI6, 4'b0010, {3'd0,3'd0,3'd3,3'd0}, 2'b00, 0, 8'h08);
    step(0, 0, 0, ADDI6, 4'b0010, {3'd0,3'd0,3'd3,3'd0}, 2'b00, 0, 8'h08);
    // ADDI r6, LD r5, then flush with en=0 clears D and X
    step(0, 1, 0, ADDI6, 4'b1001, {3'd6,3'd0,3'd0,3'd3}, 2'b00, 0, 8'h40);
    step(0, 1, 0, LD5,   4'b1100, {3'd5,3'd6,3'd0,3'd0}, 2'b00, 0, 8'h60);
    step(0, 0, 1, ADD3,  4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h00);
    // back-to-back writers of r3, then double decrement on flush with en=0
    step(0, 1, 0, ADD3,  4'b1000, {3'd3,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h08);
    step(0, 1, 0, ADD3,  4'b1100, {3'd3,3'd3,3'd0,3'd0}, 2'b00, 0, 8'h08);
    step(0, 1, 0, ADD3,  4'b1110, {3'd3,3'd3,3'd3,3'd0}, 2'b00, 0, 8'h08);
    step(0, 1, 0, ADD3,  4'b1111, {3'd3,3'd3,3'd3,3'd3}, 2'b00, 0, 8'h08);
    step(0, 0, 1, ADD3,  4'b0011, {3'd0,3'd0,3'd3,3'd3}, 2'b00, 0, 8'h08);
    step(0, 1, 0, NOP,   4'b0001, {3'd0,3'd0,3'd0,3'd3}, 2'b00, 0, 8'h00);
    // branches and HALT with one stall cycle
    step(0, 1, 0, BEQZ,  4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b10, 0, 8'h00);
    step(0, 1, 0, JR,    4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b11, 0, 8'h00);
    step(0, 1, 0, HALT,  4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b01, 0, 8'h00);
    step(0, 1, 0, NOP,   4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h00);
    step(0, 0, 0, NOP,   4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h00);
    step(0, 1, 0, NOP,   4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h00);
    step(0, 1, 0, NOP,   4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b00, 1, 8'h00);
    step(0, 1, 0, NOP,   4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h00);
    // HALT reaches W exactly four cycles after entry
    step(0, 1, 0, HALT,  4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h00);
    step(0, 1, 0, NOP,   4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h00);
    step(0, 1, 0, NOP,   4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h00);
    step(0, 1, 0, NOP,   4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b00, 1, 8'h00);
    step(0, 1, 0, NOP,   4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h00);
    // occupied slots held for four stall cycles, then mid-stream reset
    step(0, 1, 0, ADD3,  4'b1000, {3'd3,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h08);
    step(0, 1, 0, LBI5,  4'b1100, {3'd5,3'd3,3'd0,3'd0}, 2'b00, 0, 8'h28);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, JAL, 4'b1100, {3'd5,3'd3,3'd0,3'd0}, 2'b00, 0, 8'h28);
    step(1, 1, 1, JAL,   4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h00);
    step(0, 1, 0, NOP,   4'b0000, {3'd0,3'd0,3'd0,3'd0}, 2'b00, 0, 8'h00);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
